sha1_feeder: RTL and testbench
==============================

# sha1_feeder

Upstream sequencer for the SHA-1 round pipeline and its control generator. It accepts 512-bit message blocks as a stream of 32-bit words into a two-slot ping-pong buffer. It then drives the pipeline's word input `Din`, its load strobe `load7` and its phase strobe `phase_advance7` in the exact 80-cycle pattern each block requires. Blocks issue back-to-back whenever a filled slot is waiting; otherwise the feeder idles with all strobes low.

## Interface
- No parameters. Block length is fixed at 16 words and the round count at 80.
- `clk`  in  1  Single clock, rising edge.
- `rst_n`  in  1  Reset; synchronous, active-low.
- `word_in`  in  32  Message word, big-endian SHA-1 word order (W0 first).
- `word_valid`  in  1  `word_in` is valid this cycle.
- `word_ready`  out  1  Feeder can accept a word this cycle.
- `Din`  out  32  Word to the round pipeline.
- `load7`  out  1  Load strobe to the pipeline control generator.
- `phase_advance7`  out  1  Phase strobe to the pipeline control generator.
- `blk_start`  out  1  One-cycle pulse at round 0 of each issued block; aligned with the first `load7`.
- `busy`  out  1  Sequencer is in RUN.
- `blocks_issued`  out  32  Statistics counter (see Configuration).
- `idle_cycles`  out  32  Statistics counter (see Configuration).

## Operation
- **Buffer**
  - Two slots, each 16 x 32-bit, with a `full` flag per slot.
  - `wr_sel` selects the fill slot and `rd_sel` selects the issue slot. `wr_idx` is 4 bits.
- **Fill**
  - `word_ready` = !`full[wr_sel]`. It is a registered output.
  - A word is accepted when `word_valid` and `word_ready` are both high.
  - An accepted word is written to `slot[wr_sel][wr_idx]`, and `wr_idx` increments, wrapping at 15 to 0.
  - On the 16th accepted word (`wr_idx` = 15), `full[wr_sel]` is set and `wr_sel` toggles.
- **Sequencer states:** IDLE and RUN, with a 7-bit round counter `rnd` running 0..79.
  - IDLE -> RUN when `full[rd_sel]` = 1. The first RUN cycle has `rnd` = 0.
  - In RUN, `rnd` increments each cycle.
  - At `rnd` = 79: if the other slot (`!rd_sel`) is full, go to `rnd` = 0 of the next block with no gap. Otherwise go to IDLE.
  - `rd_sel` toggles at the end of `rnd` = 79.
- **Outputs in RUN (all registered; `rnd` is the cycle's round index)**
  - `load7` = 1 for `rnd` 0..15.
  - `Din` = `slot[rd_sel][rnd-1]` for `rnd` 1..16. `Din` lags `load7` by one cycle, because the pipeline registers `load7` before sampling `Din`.
  - `Din` = 0 at all other `rnd` values and in IDLE.
  - `phase_advance7` = 1 at `rnd` ∈ {0, 20, 40, 60}. The pulse at `rnd` 0 coincides with `load7`, which resets the downstream phase to 0.
  - `blk_start` = 1 at `rnd` 0.
- **Slot release:** `full[rd_sel]` clears at the end of `rnd` = 16, after the last word has been presented.
  - The slot may refill during `rnd` 17..79 of its own block.
  - If the fill and clear of a slot would land on the same edge, the clear wins. This cannot happen legally, because `word_ready` is low for a full slot.
- **IDLE outputs:** `load7`, `phase_advance7`, `blk_start` and `busy` are all 0.
- **Reset (`rst_n` low at a rising edge)**
  - All `full` flags, `wr_idx`, `wr_sel`, `rd_sel` and `rnd` clear to 0, and the state goes to IDLE.
  - All outputs read 0, except `word_ready`, which reads 1 from the first cycle after reset.
  - Reset mid-block discards both slots and any partially filled slot. Stimulus must restart at W0 of a new block.

## Timing
- From fill to first strobe: the 16th word is accepted at edge E. `load7`, `phase_advance7` and `blk_start` go high in the cycle following edge E+2, i.e. two cycles after the handshake cycle.
- Issue cadence is exactly one block per 80 cycles when the buffer stays fed.
- Sustained input rate is up to 16 words per 80 cycles without stalling the sequencer.
- `word_ready` falls the cycle after the 16th handshake whenever the other slot is still full.

## Configuration
- `SHA1_FEEDER_STATS_EN` defined:
  - `blocks_issued` increments at each `blk_start`.
  - `idle_cycles` increments on each IDLE cycle.
  - Both are 32-bit, wrap modulo 2^32, and clear on reset.
- Undefined: both ports are tied to 0 and no counter logic is built. Ports stay present in both cases so the interface is identical.

## Test plan
- **Single block:** after reset, stream W_k = 0x1000_0000+k for k = 0..15, one per cycle.
  - `load7` is high for 16 cycles starting two cycles after the last handshake.
  - `Din` carries 0x1000_0000..0x1000_000F on the following 16 cycles.
  - `phase_advance7` pulses at offsets 0/20/40/60.
  - The sequencer returns to IDLE after 80 cycles.
- **Back-to-back:** preload two blocks, then send a third during the first block.
  - `blk_start` pulses exactly 80 cycles apart, three times.
  - `word_ready` is low from the third block's first word until the end of `rnd` 16 of the first block.
- **Backpressure:** hold `word_valid` = 1 continuously with both slots full.
  - `word_ready` = 0 and no word is lost or duplicated.
  - Output word order matches input order across three blocks.
- **Valid gaps:** toggle `word_valid` 1/0 pseudo-randomly while filling. The issued `Din` sequence is identical to the gap-free case.
- **Reset mid-block:** assert `rst_n` = 0 for one cycle at `rnd` = 30.
  - Next cycle: all outputs are 0, `word_ready` = 1, and `busy` = 0.
  - A fresh block afterwards issues normally.
- **Stats (macro defined):**
  - After 3 blocks with 40 idle cycles between the 2nd and 3rd, `blocks_issued` = 3 and `idle_cycles` ≥ 40.
  - With the macro undefined, both ports read 0.

Source files
------------

// File: rtl/sha1_feeder.sv
// sha1_feeder: buffers 16-word SHA-1 blocks in two ping-pong slots and replays each one as the 80-cycle Din/load7/phase_advance7 pattern.
// Latency: strobes rise in the cycle after edge E+2, where E is the edge accepting the 16th word. Din lags load7 by one cycle.
// Backpressure: word_ready is low while the fill slot is still full. The sequencer never stalls mid-block.
// Optional feature: define SHA1_FEEDER_STATS_EN to build the blocks_issued / idle_cycles counters. Otherwise they are tied to 0.
module sha1_feeder (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] word_in,
   input  logic        word_valid,
   output logic        word_ready,
   output logic [31:0] Din,
   output logic        load7,
   output logic        phase_advance7,
   output logic        blk_start,
   output logic        busy,
   output logic [31:0] blocks_issued,
   output logic [31:0] idle_cycles
);

   typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

   localparam logic [6:0] LAST_RND = 7'd79;
   localparam logic [6:0] REL_RND  = 7'd16;

   state_t      state_q, state_d;
   logic [6:0]  rnd_q, rnd_d;
   logic        rd_sel_q, rd_sel_d;
   logic        wr_sel_q, wr_sel_d;
   logic [3:0]  wr_idx_q, wr_idx_d;
   logic [1:0]  full_q, full_d;
   logic [31:0] slot_q [2][16];

   logic        word_ready_q, word_ready_d;
   logic [31:0] din_q, din_d;
   logic        load7_q, load7_d;
   logic        pa_q, pa_d;
   logic        blk_q, blk_d;
   logic        busy_q, busy_d;

   logic        accept;
   logic [3:0]  rd_idx;

   assign accept = word_valid && word_ready_q;
   // Round r presents word r-1. At r = 16 the 4-bit wrap yields index 15.
   assign rd_idx = rnd_q[3:0] - 4'd1;

   // Next-state logic for the fill pointer, the slot flags, the sequencer and the output strobes.
   always_comb begin
      state_d      = state_q;
      rnd_d        = rnd_q;
      rd_sel_d     = rd_sel_q;
      wr_sel_d     = wr_sel_q;
      wr_idx_d     = wr_idx_q;
      full_d       = full_q;
      word_ready_d = word_ready_q;
      din_d        = '0;
      load7_d      = 1'b0;
      pa_d         = 1'b0;
      blk_d        = 1'b0;
      busy_d       = 1'b0;

      if (accept) begin
         wr_idx_d = wr_idx_q + 4'd1;
         if (wr_idx_q == 4'd15) begin
            full_d[wr_sel_q] = 1'b1;
            wr_sel_d         = ~wr_sel_q;
         end
      end

      case (state_q)
         IDLE: begin
            rnd_d = '0;
            if (full_q[rd_sel_q]) state_d = RUN;
         end
         RUN: begin
            busy_d  = 1'b1;
            load7_d = (rnd_q < 7'd16);
            pa_d    = (rnd_q == 7'd0) || (rnd_q == 7'd20) || (rnd_q == 7'd40) || (rnd_q == 7'd60);
            blk_d   = (rnd_q == 7'd0);
            if ((rnd_q >= 7'd1) && (rnd_q <= 7'd16)) din_d = slot_q[rd_sel_q][rd_idx];
            // The slot is released once its last word has been read. The release is applied after the fill update, so it wins on a collision.
            if (rnd_q == REL_RND) full_d[rd_sel_q] = 1'b0;
            if (rnd_q == LAST_RND) begin
               rnd_d    = '0;
               rd_sel_d = ~rd_sel_q;
               if (!full_q[~rd_sel_q]) state_d = IDLE;
            end else begin
               rnd_d = rnd_q + 7'd1;
            end
         end
         default: state_d = IDLE;
      endcase

      // word_ready is registered from the post-update flags, so it tracks !full[wr_sel] with no extra lag.
      word_ready_d = ~full_d[wr_sel_d];
   end

   // Control state and registered outputs, with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         rnd_q        <= '0;
         rd_sel_q     <= 1'b0;
         wr_sel_q     <= 1'b0;
         wr_idx_q     <= '0;
         full_q       <= '0;
         word_ready_q <= 1'b1;
         din_q        <= '0;
         load7_q      <= 1'b0;
         pa_q         <= 1'b0;
         blk_q        <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         rnd_q        <= rnd_d;
         rd_sel_q     <= rd_sel_d;
         wr_sel_q     <= wr_sel_d;
         wr_idx_q     <= wr_idx_d;
         full_q       <= full_d;
         word_ready_q <= word_ready_d;
         din_q        <= din_d;
         load7_q      <= load7_d;
         pa_q         <= pa_d;
         blk_q        <= blk_d;
         busy_q       <= busy_d;
      end
   end

   // Slot storage needs no reset, because the full flags and wr_idx decide what is valid.
   always_ff @(posedge clk) begin
      if (rst_n && accept) slot_q[wr_sel_q][wr_idx_q] <= word_in;
   end

   assign word_ready     = word_ready_q;
   assign Din            = din_q;
   assign load7          = load7_q;
   assign phase_advance7 = pa_q;
   assign blk_start      = blk_q;
   assign busy           = busy_q;

`ifdef SHA1_FEEDER_STATS_EN
   logic [31:0] blocks_q, idle_q;

   // Block and idle-cycle counters, kept in step with the registered strobes. They wrap modulo 2^32.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         blocks_q <= '0;
         idle_q   <= '0;
      end else begin
         if (blk_d)            blocks_q <= blocks_q + 32'd1;
         if (state_q == IDLE)  idle_q   <= idle_q + 32'd1;
      end
   end

   assign blocks_issued = blocks_q;
   assign idle_cycles   = idle_q;
`else
   assign blocks_issued = '0;
   assign idle_cycles   = '0;
`endif

endmodule

// File: tb/tb_sha1_feeder.sv
// Bench for sha1_feeder: a queue scoreboard of accepted words is checked against Din, and strobe timing is checked per scenario.
module tb_sha1_feeder;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] word_in = '0;
   logic        word_valid = 1'b0;
   logic        word_ready;
   logic [31:0] Din;
   logic        load7;
   logic        phase_advance7;
   logic        blk_start;
   logic        busy;
   logic [31:0] blocks_issued;
   logic [31:0] idle_cycles;

   int          n_checks = 0;
   int          n_fail = 0;
   logic [31:0] exp_q[$];
   int          hs_count = 0;
   int          stall_cycles = 0;
   bit          feed_abort = 1'b0;

   always #5 clk = ~clk;

   sha1_feeder dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .word_in        (word_in),
      .word_valid     (word_valid),
      .word_ready     (word_ready),
      .Din            (Din),
      .load7          (load7),
      .phase_advance7 (phase_advance7),
      .blk_start      (blk_start),
      .busy           (busy),
      .blocks_issued  (blocks_issued),
      .idle_cycles    (idle_cycles)
   );

   // Driver: offers words base+k. Each accepted word is pushed onto the scoreboard at its handshake edge.
   task automatic feed(input logic [31:0] base, input int n, input bit gaps);
      int   k = 0;
      int   guard = 0;
      logic hs;
      hs_count     = 0;
      stall_cycles = 0;
      while (k < n && guard < 4000 && !feed_abort) begin
         word_in    = base + 32'(k);
         word_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
         @(negedge clk);
         hs = word_valid && word_ready;
         if (word_valid && !word_ready) stall_cycles++;
         @(posedge clk);
         #1;
         if (hs) begin
            exp_q.push_back(word_in);
            k++;
            hs_count = k;
         end
         guard++;
      end
      word_valid = 1'b0;
      word_in    = '0;
   endtask

   task automatic stop_feed();
      feed_abort = 1'b1;
      repeat (2) begin @(posedge clk); #1; end
      feed_abort = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) begin @(posedge clk); #1; end
      @(negedge clk);
      n_checks++; if (word_ready !== 1'b1) begin n_fail++; $display("FAIL reset_word_ready: got %b want 1", word_ready); end
      n_checks++; if (load7 !== 1'b0) begin n_fail++; $display("FAIL reset_load7: got %b want 0", load7); end
      n_checks++; if (phase_advance7 !== 1'b0) begin n_fail++; $display("FAIL reset_phase: got %b want 0", phase_advance7); end
      n_checks++; if (blk_start !== 1'b0) begin n_fail++; $display("FAIL reset_blk_start: got %b want 0", blk_start); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
      n_checks++; if (Din !== 32'h0) begin n_fail++; $display("FAIL reset_din: got %h want 0", Din); end
      n_checks++; if (blocks_issued !== 32'h0) begin n_fail++; $display("FAIL reset_blocks: got %0d want 0", blocks_issued); end
      n_checks++; if (idle_cycles !== 32'h0) begin n_fail++; $display("FAIL reset_idle: got %0d want 0", idle_cycles); end
      rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   // t = 0 is the cycle after the 16th handshake edge. Every expected value below comes from that reference.
   task automatic test_single_block();
      logic [31:0] e;
      logic        el7, epa, ebs, ebusy;
      exp_q.delete();
      feed(32'h1000_0000, 16, 1'b0);
      n_checks++; if (hs_count !== 16) begin n_fail++; $display("FAIL single_handshakes: got %0d want 16", hs_count); end
      for (int t = 0; t < 90; t++) begin
         @(negedge clk);
         el7   = (t >= 2 && t < 18);
         epa   = (t == 2 || t == 22 || t == 42 || t == 62);
         ebs   = (t == 2);
         ebusy = (t >= 2 && t < 82);
         if (t >= 3 && t < 19) e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
         else e = 32'h0;
         n_checks++; if (load7 !== el7) begin n_fail++; $display("FAIL single_load7 t=%0d: got %b want %b", t, load7, el7); end
         n_checks++; if (phase_advance7 !== epa) begin n_fail++; $display("FAIL single_phase t=%0d: got %b want %b", t, phase_advance7, epa); end
         n_checks++; if (blk_start !== ebs) begin n_fail++; $display("FAIL single_blk_start t=%0d: got %b want %b", t, blk_start, ebs); end
         n_checks++; if (busy !== ebusy) begin n_fail++; $display("FAIL single_busy t=%0d: got %b want %b", t, busy, ebusy); end
         n_checks++; if (Din !== e) begin n_fail++; $display("FAIL single_din t=%0d: got %h want %h", t, Din, e); end
         @(posedge clk); #1;
      end
      n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL single_leftover: got %0d words want 0", exp_q.size()); end
   endtask

   task automatic test_valid_gaps();
      logic [31:0] e;
      logic        el7;
      exp_q.delete();
      feed(32'h1000_0000, 16, 1'b1);
      n_checks++; if (hs_count !== 16) begin n_fail++; $display("FAIL gaps_handshakes: got %0d want 16", hs_count); end
      for (int t = 0; t < 90; t++) begin
         @(negedge clk);
         el7 = (t >= 2 && t < 18);
         e   = (t >= 3 && t < 19) ? 32'h1000_0000 + 32'(t - 3) : 32'h0;
         n_checks++; if (load7 !== el7) begin n_fail++; $display("FAIL gaps_load7 t=%0d: got %b want %b", t, load7, el7); end
         n_checks++; if (Din !== e) begin n_fail++; $display("FAIL gaps_din t=%0d: got %h want %h", t, Din, e); end
         @(posedge clk); #1;
      end
      exp_q.delete();
   endtask

   task automatic test_back_to_back();
      int          starts[$];
      bit          prev_l7 = 1'b0;
      bit          rdy_seen = 1'b0;
      int          din_stray = 0;
      int          t33 = -1;
      logic [31:0] e;
      exp_q.delete();
      fork feed(32'h2000_0000, 48, 1'b0); join_none
      for (int t = 0; t < 400; t++) begin
         @(negedge clk);
         if (blk_start) starts.push_back(t);
         if (prev_l7) begin
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
            n_checks++; if (Din !== e) begin n_fail++; $display("FAIL b2b_din t=%0d: got %h want %h", t, Din, e); end
         end else if (Din !== 32'h0) din_stray++;
         if (hs_count == 32 && !rdy_seen) begin
            rdy_seen = 1'b1;
            n_checks++; if (word_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_ready_low: got %b want 0", word_ready); end
         end
         if (hs_count == 33 && t33 < 0) t33 = t;
         prev_l7 = load7;
         @(posedge clk); #1;
      end
      stop_feed();
      n_checks++; if (hs_count !== 48) begin n_fail++; $display("FAIL b2b_handshakes: got %0d want 48", hs_count); end
      n_checks++; if (starts.size() != 3) begin n_fail++; $display("FAIL b2b_starts: got %0d want 3", starts.size()); end
      if (starts.size() == 3) begin
         n_checks++; if (starts[1] - starts[0] != 80) begin n_fail++; $display("FAIL b2b_gap1: got %0d want 80", starts[1] - starts[0]); end
         n_checks++; if (starts[2] - starts[1] != 80) begin n_fail++; $display("FAIL b2b_gap2: got %0d want 80", starts[2] - starts[1]); end
      end
      if (starts.size() > 0) begin
         n_checks++;
         if (t33 < starts[0] + 16 || t33 > starts[0] + 20) begin
            n_fail++; $display("FAIL b2b_refill_time: got t=%0d want within %0d..%0d", t33, starts[0] + 16, starts[0] + 20);
         end
      end
      n_checks++; if (din_stray != 0) begin n_fail++; $display("FAIL b2b_din_stray: got %0d want 0", din_stray); end
      n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL b2b_leftover: got %0d want 0", exp_q.size()); end
   endtask

   task automatic test_backpressure();
      int          starts[$];
      bit          prev_l7 = 1'b0;
      bit          rdy_seen = 1'b0;
      logic [31:0] e;
      exp_q.delete();
      fork feed(32'h2100_0000, 64, 1'b0); join_none
      for (int t = 0; t < 420; t++) begin
         @(negedge clk);
         if (blk_start) starts.push_back(t);
         if (prev_l7) begin
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
            n_checks++; if (Din !== e) begin n_fail++; $display("FAIL bp_din t=%0d: got %h want %h", t, Din, e); end
         end
         if (hs_count == 48 && !rdy_seen) begin
            rdy_seen = 1'b1;
            n_checks++; if (word_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready_low: got %b want 0", word_ready); end
         end
         prev_l7 = load7;
         @(posedge clk); #1;
      end
      stop_feed();
      n_checks++; if (hs_count !== 64) begin n_fail++; $display("FAIL bp_handshakes: got %0d want 64", hs_count); end
      n_checks++; if (stall_cycles < 60) begin n_fail++; $display("FAIL bp_stall: got %0d want >= 60", stall_cycles); end
      n_checks++; if (starts.size() != 4) begin n_fail++; $display("FAIL bp_starts: got %0d want 4", starts.size()); end
      n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL bp_leftover: got %0d want 0", exp_q.size()); end
   endtask

   task automatic test_reset_mid();
      bit          prev_l7 = 1'b0;
      int          nstart = 0;
      logic [31:0] e;
      exp_q.delete();
      feed(32'h3000_0000, 21, 1'b0);
      repeat (26) begin @(posedge clk); #1; end
      n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL mid_busy_before: got %b want 1", busy); end
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk);
      n_checks++; if (word_ready !== 1'b1) begin n_fail++; $display("FAIL mid_word_ready: got %b want 1", word_ready); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mid_busy: got %b want 0", busy); end
      n_checks++; if (load7 !== 1'b0) begin n_fail++; $display("FAIL mid_load7: got %b want 0", load7); end
      n_checks++; if (phase_advance7 !== 1'b0) begin n_fail++; $display("FAIL mid_phase: got %b want 0", phase_advance7); end
      n_checks++; if (blk_start !== 1'b0) begin n_fail++; $display("FAIL mid_blk_start: got %b want 0", blk_start); end
      n_checks++; if (Din !== 32'h0) begin n_fail++; $display("FAIL mid_din: got %h want 0", Din); end
      n_checks++; if (blocks_issued !== 32'h0) begin n_fail++; $display("FAIL mid_blocks: got %0d want 0", blocks_issued); end
      @(posedge clk); #1;
      exp_q.delete();
      feed(32'h4000_0000, 16, 1'b0);
      for (int t = 0; t < 90; t++) begin
         @(negedge clk);
         if (blk_start) nstart++;
         if (prev_l7) begin
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
            n_checks++; if (Din !== e) begin n_fail++; $display("FAIL mid_fresh_din t=%0d: got %h want %h", t, Din, e); end
         end
         prev_l7 = load7;
         @(posedge clk); #1;
      end
      n_checks++; if (nstart != 1) begin n_fail++; $display("FAIL mid_fresh_starts: got %0d want 1", nstart); end
      n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL mid_fresh_leftover: got %0d want 0", exp_q.size()); end
   endtask

   task automatic test_stats();
      bit seen_busy = 1'b0;
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      exp_q.delete();
      feed(32'h5000_0000, 32, 1'b0);
      for (int t = 0; t < 400; t++) begin
         @(negedge clk);
         if (busy) seen_busy = 1'b1;
         else if (seen_busy) break;
         @(posedge clk); #1;
      end
      n_checks++; if (!(seen_busy && !busy)) begin n_fail++; $display("FAIL stats_drain: got busy=%b seen=%b want idle after run", busy, seen_busy); end
      @(posedge clk); #1;
      repeat (40) begin @(posedge clk); #1; end
      feed(32'h5000_0020, 16, 1'b0);
      repeat (120) begin @(posedge clk); #1; end
      @(negedge clk);
`ifdef SHA1_FEEDER_STATS_EN
      n_checks++; if (blocks_issued !== 32'd3) begin n_fail++; $display("FAIL stats_blocks: got %0d want 3", blocks_issued); end
      n_checks++; if (idle_cycles < 32'd40) begin n_fail++; $display("FAIL stats_idle: got %0d want >= 40", idle_cycles); end
`else
      n_checks++; if (blocks_issued !== 32'd0) begin n_fail++; $display("FAIL stats_blocks_off: got %0d want 0", blocks_issued); end
      n_checks++; if (idle_cycles !== 32'd0) begin n_fail++; $display("FAIL stats_idle_off: got %0d want 0", idle_cycles); end
`endif
      @(posedge clk); #1;
      exp_q.delete();
   endtask

   initial begin
      #1;
      test_reset();
      test_single_block();
      test_valid_gaps();
      test_back_to_back();
      test_backpressure();
      test_reset_mid();
      test_stats();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
